// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: packs 32-bit big-endian words into 512-bit chunks and
// appends the 0x80 marker, zero fill and 64-bit bit-length.
module sha1_msg_padder #(
    parameter int C_SHA_CHUNK_SIZE = 512,
    parameter int C_WORD_SIZE      = 32,
    parameter int C_LEN_WIDTH      = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [C_WORD_SIZE-1:0]      in_word,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [2:0]                  in_bytes,
    output logic [C_SHA_CHUNK_SIZE-1:0] out_chunk,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_first,
    output logic                        out_final,
    output logic                        busy
);

    localparam int NW = C_SHA_CHUNK_SIZE / C_WORD_SIZE;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [3:0]                       idx_q, idx_d;
    logic [NW-1:0][C_WORD_SIZE-1:0]   buf_q, buf_d;
    logic [C_LEN_WIDTH-1:0]           len_q, len_d;
    logic                             first_q, first_d;
    logic                             marker_q, marker_d;
    logic                             lenhi_q, lenhi_d;
    logic                             ended_q, ended_d;
    logic                             out_first_q, out_first_d;
    logic                             out_final_q, out_final_d;
    logic                             in_ready_q, out_valid_q, busy_q;
    logic [C_WORD_SIZE-1:0]           wdata_s;
    logic [5:0]                       add_s;
    logic [63:0]                      len64_s;

    assign len64_s   = 64'(len_q);
    // Word 0 lives in the top slot of the packed buffer, so it lands in [511:480].
    assign out_chunk = buf_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_first = out_first_q;
    assign out_final = out_final_q;
    assign busy      = busy_q;

    // Next-state computation for the fill / pad / emit sequence.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        len_d       = len_q;
        first_d     = first_q;
        marker_d    = marker_q;
        lenhi_d     = lenhi_q;
        ended_d     = ended_q;
        out_first_d = out_first_q;
        out_final_d = out_final_q;
        wdata_s     = 32'h0000_0000;
        add_s       = 6'd0;
        case (state_q)
            S_FILL: begin
                if (in_valid && in_ready_q) begin
                    if (!in_last) begin
                        wdata_s = in_word;
                        add_s   = 6'd32;
                    end else begin
                        ended_d = 1'b1;
                        case (in_bytes)
                            3'd0: begin wdata_s = 32'h8000_0000;                 add_s = 6'd0;  end
                            3'd1: begin wdata_s = {in_word[31:24], 24'h80_0000}; add_s = 6'd8;  end
                            3'd2: begin wdata_s = {in_word[31:16], 16'h8000};    add_s = 6'd16; end
                            3'd3: begin wdata_s = {in_word[31:8], 8'h80};        add_s = 6'd24; end
                            default: begin
                                wdata_s  = in_word;
                                add_s    = 6'd32;
                                marker_d = 1'b1;
                            end
                        endcase
                    end
                    buf_d[4'd15 - idx_q] = wdata_s;
                    len_d = len_q + C_LEN_WIDTH'(add_s);
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d     = S_EMIT;
                        out_first_d = first_q;
                    end else if (in_last) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_PAD: begin
                if (marker_q) begin
                    wdata_s  = 32'h8000_0000;
                    marker_d = 1'b0;
                end else if (idx_q == 4'd14) begin
                    wdata_s = len64_s[63:32];
                    lenhi_d = 1'b1;
                end else if (idx_q == 4'd15 && lenhi_q) begin
                    wdata_s     = len64_s[31:0];
                    out_final_d = 1'b1;
                end else begin
                    wdata_s = 32'h0000_0000;
                end
                buf_d[4'd15 - idx_q] = wdata_s;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d     = S_EMIT;
                    out_first_d = first_q;
                end else begin
                    state_d = S_PAD;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    idx_d       = 4'd0;
                    buf_d       = '0;
                    first_d     = 1'b0;
                    out_first_d = 1'b0;
                    out_final_d = 1'b0;
                    if (out_final_q) begin
                        len_d   = '0;
                        first_d = 1'b1;
                        lenhi_d = 1'b0;
                        ended_d = 1'b0;
                        state_d = S_FILL;
                    end else if (ended_q) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State and registered handshake / status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            idx_q       <= 4'd0;
            buf_q       <= '0;
            len_q       <= '0;
            first_q     <= 1'b1;
            marker_q    <= 1'b0;
            lenhi_q     <= 1'b0;
            ended_q     <= 1'b0;
            out_first_q <= 1'b0;
            out_final_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            len_q       <= len_d;
            first_q     <= first_d;
            marker_q    <= marker_d;
            lenhi_q     <= lenhi_d;
            ended_q     <= ended_d;
            out_first_q <= out_first_d;
            out_final_q <= out_final_d;
            in_ready_q  <= (state_d == S_FILL);
            out_valid_q <= (state_d == S_EMIT);
            busy_q      <= (idx_d != 4'd0) || (state_d != S_FILL) || !first_d;
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Randomized bench for sha1_msg_padder against a byte-level FIPS 180-4 padding model.
module tb_sha1_msg_padder;

    logic         clk;
    logic         rst;
    logic [31:0]  in_word;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic [511:0] out_chunk;
    logic         out_valid;
    logic         out_ready;
    logic         out_first;
    logic         out_final;
    logic         busy;

    int checks_r   = 0;
    int failures_r = 0;

    logic [7:0]   msg_q[$];
    logic [511:0] exp_chunks_q[$];
    logic [511:0] last_chunk_r;

    sha1_msg_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .out_chunk (out_chunk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_final (out_final),
        .busy      (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Padded message = bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
    task automatic build_expected();
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] ch;
        p = msg_q;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        exp_chunks_q.delete();
        for (int c = 0; c < p.size() / 64; c++) begin
            ch = '0;
            for (int b = 0; b < 64; b++) ch[511 - 8*b -: 8] = p[64*c + b];
            exp_chunks_q.push_back(ch);
        end
    endtask

    task automatic run_msg(input bit bp);
        int L, nw, wi, ci, cyc, bp_cnt, k;
        L  = msg_q.size();
        nw = (L == 0) ? 1 : (L + 3) / 4;
        build_expected();
        wi = 0; ci = 0; cyc = 0; bp_cnt = 0;
        while (ci < exp_chunks_q.size() && cyc < 3000) begin
            @(posedge clk); #1;
            if (wi < nw && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    k = 4*wi + b;
                    in_word[31 - 8*b -: 8] = (k < L) ? msg_q[k] : 8'($urandom);
                end
                in_last = (wi == nw - 1);
                if (wi == nw - 1)
                    in_bytes = (L - 4*wi >= 4) ? 3'($urandom_range(4, 7)) : 3'(L - 4*wi);
                else
                    in_bytes = 3'($urandom_range(0, 7));
            end else begin
                in_valid = 1'b0;
                in_word  = $urandom;
                in_last  = 1'($urandom);
                in_bytes = 3'($urandom);
            end
            out_ready = (bp && bp_cnt < 10) ? 1'b0 : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) wi++;
            if (out_valid) check_eq("in_ready_in_emit", in_ready, 1'b0);
            if (bp && bp_cnt < 10 && out_valid) begin
                check_eq("bp_valid", out_valid, 1'b1);
                check_eq("bp_chunk", out_chunk, exp_chunks_q[ci]);
                bp_cnt++;
            end
            if (out_valid && out_ready) begin
                check_eq("chunk", out_chunk, exp_chunks_q[ci]);
                check_eq("first", out_first, (ci == 0));
                check_eq("final", out_final, (ci == exp_chunks_q.size() - 1));
                last_chunk_r = out_chunk;
                ci++;
            end
            cyc++;
        end
        if (ci < exp_chunks_q.size()) check_eq("timeout_chunks", 512'(ci), 512'(exp_chunks_q.size()));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_in_ready", in_ready, 1'b1);
        check_eq("idle_out_valid", out_valid, 1'b0);
    endtask

    task automatic set_rand_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    // Directed cases first, then random message lengths.
    initial begin
        logic [511:0] exp_c;
        rst = 1'b1; in_word = 32'h0; in_valid = 1'b0; in_last = 1'b0;
        in_bytes = 3'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_first", out_first, 1'b0);
        check_eq("rst_final", out_final, 1'b0);
        check_eq("rst_chunk", out_chunk, 512'h0);
        @(negedge clk); rst = 1'b0;

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0);
        exp_c = {32'h6162_6380, 448'h0, 32'h0000_0018};
        check_eq("abc_literal", last_chunk_r, exp_c);

        msg_q.delete();
        run_msg(1'b0);
        exp_c = {32'h8000_0000, 480'h0};
        check_eq("empty_literal", last_chunk_r, exp_c);

        set_rand_msg(56);
        run_msg(1'b0);
        exp_c = {480'h0, 32'h0000_01C0};
        check_eq("len56_literal", last_chunk_r, exp_c);

        set_rand_msg(64);
        run_msg(1'b0);
        exp_c = {32'h8000_0000, 448'h0, 32'h0000_0200};
        check_eq("len64_literal", last_chunk_r, exp_c);

        set_rand_msg(20);
        run_msg(1'b1);

        // Abandon a message after five words with an asynchronous reset.
        @(posedge clk); #1;
        in_valid = 1'b1; in_last = 1'b0; in_bytes = 3'd0;
        for (int i = 0; i < 5; i++) begin
            in_word = $urandom;
            @(posedge clk); #1;
        end
        check_eq("pre_rst_busy", busy, 1'b1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_in_ready", in_ready, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_chunk", out_chunk, 512'h0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0);
        exp_c = {32'h6162_6380, 448'h0, 32'h0000_0018};
        check_eq("abc_after_rst", last_chunk_r, exp_c);

        foreach (exp_c[i]) exp_c[i] = 1'b0;
        for (int m = 0; m < 8; m++) begin
            int blen[8] = '{55, 57, 60, 63, 119, 120, 4, 1};
            set_rand_msg(blen[m]);
            run_msg(1'b0);
        end
        for (int m = 0; m < 25; m++) begin
            set_rand_msg($urandom_range(0, 150));
            run_msg(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
